xnor_match_accumulator: RTL and testbench
=========================================

XNOR_MATCH_ACCUMULATOR -- requirements
Module: xnor_match_accumulator

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 8, meaning the number of XNOR result bits per compared word; legal range 2..255.
REQ-002 The block SHALL derive localparam CW = clog2(WORD_WIDTH+1), the count/index width.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port DigitSupply, input, 2 bits: supply rail pair; [1] = high rail, [0] = low rail; powered when the value is 2'b10.
REQ-006 The block SHALL have port Start, input, 1 bit: pulse that begins accumulation of a new word.
REQ-007 The block SHALL have port BitValid, input, 1 bit: XnorBit carries a valid result this cycle.
REQ-008 The block SHALL have port XnorBit, input, 1 bit: per-bit equality result from the upstream xnor stage; 1 = bits equal.
REQ-009 The block SHALL have port Busy, output, 1 bit: accumulation in progress.
REQ-010 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking valid results.
REQ-011 The block SHALL have port Equal, output, 1 bit: all WORD_WIDTH bits matched.
REQ-012 The block SHALL have port MatchCount, output, CW bits: the number of XnorBit=1 results in the word.
REQ-013 The block SHALL have port MismatchIndex, output, CW bits: the index of the first XnorBit=0, or WORD_WIDTH if there is none.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM and DONE; all outputs SHALL be registered.
REQ-015 In IDLE: Busy=0, Done=0; BitValid ignored; Start=1 SHALL clear the bit counter, MatchCount=0 and MismatchIndex=WORD_WIDTH, then move to ACCUM.
REQ-016 In ACCUM: Busy=1; each cycle with BitValid=1 SHALL consume XnorBit as BitIndex (first bit = 0) and increment BitIndex.
REQ-017 In ACCUM, a consumed XnorBit=1 SHALL increment MatchCount; a consumed XnorBit=0 SHALL set MismatchIndex=BitIndex only if MismatchIndex still equals WORD_WIDTH.
REQ-018 In ACCUM, BitValid=0 SHALL hold all state with no timeout.
REQ-019 Consuming bit index WORD_WIDTH-1 SHALL move the FSM to DONE.
REQ-020 In DONE: Done=1, Busy=0, Equal=(MatchCount==WORD_WIDTH) for exactly one cycle, then IDLE.
REQ-021 Equal, MatchCount and MismatchIndex SHALL hold stable after DONE until the next accepted Start.
REQ-022 Latency: with Start at cycle t and BitValid continuously high from t+1, Done SHALL assert at cycle t+WORD_WIDTH+1.
REQ-023 Start in ACCUM SHALL restart: results cleared, state stays ACCUM, and any same-cycle BitValid/XnorBit is discarded.
REQ-024 Start in DONE SHALL be accepted: Done=1 still shown that cycle, then ACCUM with cleared results.
REQ-025 Equal SHALL be 0 whenever Done has not yet pulsed for the current word.
REQ-026 BitIndex SHALL never exceed WORD_WIDTH-1; MatchCount SHALL never exceed WORD_WIDTH, with no wrap.
REQ-027 When DigitSupply != 2'b10, the block SHALL freeze all state, ignore Start and BitValid, and drive Busy=0 and Done=0.
REQ-028 Result outputs SHALL hold while DigitSupply != 2'b10; operation SHALL resume from the frozen state when DigitSupply returns to 2'b10.

Reset
REQ-029 Reset=1 at a rising Clock edge SHALL force IDLE, Busy=0, Done=0, Equal=0, MatchCount=0, MismatchIndex=WORD_WIDTH and BitIndex=0.
REQ-030 Reset SHALL take priority over Start, BitValid and DigitSupply.
REQ-031 Reset mid-ACCUM or in DONE SHALL abandon the word with no Done pulse.

Verification
REQ-032 WORD_WIDTH=8, Start then 8 valid bits all 1 -> Done at t+9, Equal=1, MatchCount=8, MismatchIndex=8.
REQ-033 Bits 1,1,1,0,1,0,1,1 with BitValid gaps of 2 cycles -> Equal=0, MatchCount=6, MismatchIndex=3; Busy high throughout the gaps.
REQ-034 Start again after bit 4 of a word -> results cleared, 8 further bits required, the same-cycle bit discarded.
REQ-035 Start in the DONE cycle -> Done=1 that cycle, Busy=1 next cycle, the next word is accumulated correctly.
REQ-036 DigitSupply=2'b00 for 3 cycles mid-word, with BitValid=1 -> no bits consumed, Busy=0; resume gives correct totals.
REQ-037 Reset asserted in ACCUM with Start held high -> IDLE next cycle, all outputs at reset values, no Done pulse.

Source files
------------

// File: rtl/xnor_match_accumulator.sv
// Serial XNOR-result accumulator: counts matching bits of one word, records the
// first mismatch position and flags a full-word match once all bits have arrived.
module xnor_match_accumulator #(
  parameter int WORD_WIDTH = 8,
  localparam int CW = $clog2(WORD_WIDTH + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [1:0]    DigitSupply,
  input  logic          Start,
  input  logic          BitValid,
  input  logic          XnorBit,
  output logic          Busy,
  output logic          Done,
  output logic          Equal,
  output logic [CW-1:0] MatchCount,
  output logic [CW-1:0] MismatchIndex
);

  localparam logic [CW-1:0] LP_W    = CW'(WORD_WIDTH);
  localparam logic [CW-1:0] LP_LAST = CW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_busy;
  logic          r_done;
  logic          r_equal;
  logic [CW-1:0] r_match_cnt;
  logic [CW-1:0] r_mis_idx;
  logic [CW-1:0] r_bit_idx;

  logic          w_pwr;
  logic          w_start_acc;
  logic          w_consume;
  logic          w_last;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic [CW-1:0] w_match_nxt;

  // Count never wraps past a full word.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    if (en && (v != LP_W)) return v + CW'(1);
    return v;
  endfunction

  assign w_pwr       = (DigitSupply == 2'b10);
  assign w_start_acc = w_pwr && Start;
  // A restart wins over a same-cycle bit, which is dropped.
  assign w_consume   = w_pwr && (r_state == S_ACCUM) && !Start && BitValid;
  assign w_last      = w_consume && (r_bit_idx == LP_LAST);
  assign w_match_nxt = sat_inc(r_match_cnt, XnorBit);

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_pwr) begin
      unique case (r_state)
        S_IDLE:  if (Start) w_state_nxt = S_ACCUM;
        S_ACCUM: begin
          if (Start)       w_state_nxt = S_ACCUM;
          else if (w_last) w_state_nxt = S_DONE;
        end
        S_DONE:  w_state_nxt = Start ? S_ACCUM : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Status flags are registered from the next state; an unpowered block shows neither.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (w_pwr) begin
      w_busy_nxt = (w_state_nxt == S_ACCUM);
      w_done_nxt = (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || w_start_acc) begin
      r_bit_idx   <= '0;
      r_match_cnt <= '0;
      r_mis_idx   <= LP_W;
      r_equal     <= 1'b0;
    end else if (w_consume) begin
      r_match_cnt <= w_match_nxt;
      if (!XnorBit && (r_mis_idx == LP_W)) r_mis_idx <= r_bit_idx;
      if (w_last) begin
        r_equal   <= (w_match_nxt == LP_W);
        r_bit_idx <= '0;
      end else begin
        r_bit_idx <= r_bit_idx + CW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      assert (r_bit_idx <= LP_LAST);
      assert (r_match_cnt <= LP_W);
      assert (!(r_busy && r_done));
    end
  end

  assign Busy          = r_busy;
  assign Done          = r_done;
  assign Equal         = r_equal;
  assign MatchCount    = r_match_cnt;
  assign MismatchIndex = r_mis_idx;

endmodule

// File: tb/tb_xnor_match_accumulator.sv
// Bench for xnor_match_accumulator: word-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_xnor_match_accumulator;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          Clock = 1'b0;
  logic          Reset;
  logic [1:0]    DigitSupply;
  logic          Start;
  logic          BitValid;
  logic          XnorBit;
  logic          Busy;
  logic          Done;
  logic          Equal;
  logic [CW-1:0] MatchCount;
  logic [CW-1:0] MismatchIndex;

  int errors = 0;
  int checks = 0;

  xnor_match_accumulator #(.WORD_WIDTH(W)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .DigitSupply  (DigitSupply),
    .Start        (Start),
    .BitValid     (BitValid),
    .XnorBit      (XnorBit),
    .Busy         (Busy),
    .Done         (Done),
    .Equal        (Equal),
    .MatchCount   (MatchCount),
    .MismatchIndex(MismatchIndex)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the bits of the current word kept as a list; results derived from it.
  int m_mode;            // 0 idle, 1 collecting, 2 word just completed
  int m_bits[$];
  bit m_eq, m_busy, m_done;

  function automatic int model_matches();
    int n = 0;
    foreach (m_bits[i]) n += m_bits[i];
    return n;
  endfunction

  function automatic int model_first_zero();
    foreach (m_bits[i]) if (m_bits[i] == 0) return i;
    return W;
  endfunction

  initial begin
    m_mode = 0; m_eq = 0; m_busy = 0; m_done = 0;
    forever begin
      @(posedge Clock);
      if (Reset) begin
        m_mode = 0; m_bits.delete(); m_eq = 0; m_busy = 0; m_done = 0;
      end else if (DigitSupply != 2'b10) begin
        m_busy = 0; m_done = 0;
      end else begin
        if (Start) begin
          m_bits.delete(); m_eq = 0; m_mode = 1;
        end else if (m_mode == 1) begin
          if (BitValid) begin
            m_bits.push_back(int'(XnorBit));
            if (m_bits.size() == W) begin
              m_mode = 2;
              m_eq   = (model_matches() == W);
            end
          end
        end else if (m_mode == 2) begin
          m_mode = 0;
        end
        m_busy = (m_mode == 1);
        m_done = (m_mode == 2);
      end
      @(negedge Clock);
      chk("busy",  Busy,  m_busy);
      chk("done",  Done,  m_done);
      chk("equal", Equal, m_eq);
      chk("match_count",    MatchCount,    model_matches());
      chk("mismatch_index", MismatchIndex, model_first_zero());
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  Busy, 0);
    chk({tag, "_done"},  Done, 0);
    chk({tag, "_equal"}, Equal, 0);
    chk({tag, "_mc"},    MatchCount, 0);
    chk({tag, "_mi"},    MismatchIndex, W);
  endtask

  // Call with Start already driven for this cycle; returns at the cycle Done shows.
  task automatic word(input logic [W-1:0] pat, input int gap, output int lat);
    int idx = 0;
    int g   = 0;
    tick();
    Start = 1'b0;
    lat   = 1;
    chk("busy_after_start", Busy, 1);
    while (!Done && lat < 80) begin
      if (idx < W && g == 0) begin
        BitValid = 1'b1; XnorBit = pat[idx]; idx++; g = gap;
      end else begin
        if (idx > 0 && idx < W) chk("busy_in_gap", Busy, 1);
        BitValid = 1'b0; XnorBit = 1'b0;
        if (g > 0) g--;
      end
      tick();
      lat++;
    end
    BitValid = 1'b0;
    if (!Done) chk("done_timeout", 0, 1);
  endtask

  task automatic send_bit(input logic b);
    BitValid = 1'b1; XnorBit = b;
    tick();
  endtask

  int lat;

  initial begin
    Reset = 1'b1; DigitSupply = 2'b10; Start = 1'b0; BitValid = 1'b0; XnorBit = 1'b0;
    repeat (2) tick();
    chk_reset_vals("reset");
    Reset = 1'b0;
    tick();

    // All-ones word, back-to-back bits.
    Start = 1'b1;
    word(8'hFF, 0, lat);
    chk("latency_all_ones", lat, W + 1);
    chk("all_ones_equal", Equal, 1);
    chk("all_ones_mc", MatchCount, 8);
    chk("all_ones_mi", MismatchIndex, 8);
    tick();
    chk("done_one_cycle", Done, 0);
    chk("equal_holds", Equal, 1);
    tick();

    // Bits 1,1,1,0,1,0,1,1 (bit0 first) with two idle cycles between bits.
    Start = 1'b1;
    word(8'b1101_0111, 2, lat);
    chk("gap_equal", Equal, 0);
    chk("gap_mc", MatchCount, 6);
    chk("gap_mi", MismatchIndex, 3);

    // Restart after four bits; the restart-cycle bit (a zero) must be dropped.
    tick();
    Start = 1'b1; tick(); Start = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    Start = 1'b1; BitValid = 1'b1; XnorBit = 1'b0;
    word(8'hFF, 0, lat);
    chk("restart_latency", lat, W + 1);
    chk("restart_equal", Equal, 1);
    chk("restart_mc", MatchCount, 8);
    chk("restart_mi", MismatchIndex, 8);

    // Start presented in the Done cycle.
    Start = 1'b1;
    chk("start_in_done_done", Done, 1);
    word(8'b1111_1110, 0, lat);
    chk("next_word_latency", lat, W + 1);
    chk("next_word_mc", MatchCount, 7);
    chk("next_word_mi", MismatchIndex, 0);
    chk("next_word_equal", Equal, 0);

    // Supply drop mid-word with valid bits offered.
    tick();
    Start = 1'b1; tick(); Start = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    DigitSupply = 2'b00; BitValid = 1'b1; XnorBit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("unpowered_busy", Busy, 0);
      chk("unpowered_done", Done, 0);
      chk("unpowered_mc", MatchCount, 2);
    end
    DigitSupply = 2'b10;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    BitValid = 1'b0;
    chk("resume_done", Done, 1);
    chk("resume_mc", MatchCount, 7);
    chk("resume_mi", MismatchIndex, 1);
    chk("resume_equal", Equal, 0);
    tick();

    // Reset mid-word with Start held.
    Start = 1'b1; tick(); Start = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    Reset = 1'b1; Start = 1'b1; BitValid = 1'b1; XnorBit = 1'b1;
    tick();
    chk_reset_vals("reset_mid_word");
    Reset = 1'b0; Start = 1'b0; BitValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_done_after_reset", Done, 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      Reset       = ($urandom_range(199) == 0);
      Start       = ($urandom_range(24) == 0);
      BitValid    = ($urandom_range(2) != 0);
      XnorBit     = ($urandom_range(4) != 0);
      DigitSupply = ($urandom_range(19) == 0) ? 2'($urandom_range(3)) : 2'b10;
      tick();
    end
    Reset = 1'b0; Start = 1'b0; BitValid = 1'b0; DigitSupply = 2'b10;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
